// File: rtl/tft_spi_decoder.sv
// Snoops a mode-0 TFT SPI bus, emits received bytes and decodes CASET/PASET/RAMWR
// into window registers and addressed RGB565 pixels. States: IDLE, CASET, PASET, RAMWR, IGNORE.
module tft_spi_decoder #(
  parameter bit          SYNC_EN  = 1'b1,
  parameter logic [15:0] XDEF_END = 16'd239,
  parameter logic [15:0] YDEF_END = 16'd319
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        csn,
  input  logic        dcn,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dcn,
  output logic        pixel_valid,
  output logic [15:0] pixel_color,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic [15:0] win_xstart,
  output logic [15:0] win_xend,
  output logic [15:0] win_ystart,
  output logic [15:0] win_yend,
  output logic        frame_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR, ST_IGNORE} state_t;

  logic [1:0] sclk_sync_q, mosi_sync_q, csn_sync_q, dcn_sync_q;
  logic       sclk_s, mosi_s, csn_s, dcn_s;
  logic       sclk_prev_q, csn_prev_q;
  logic       edge_ok, byte_done;
  logic [7:0] new_byte;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        byte_valid_q, byte_valid_d, byte_dcn_q, byte_dcn_d, frame_err_q, frame_err_d;
  logic [7:0]  byte_data_q, byte_data_d;
  state_t      state_q, state_d;
  logic [2:0]  arg_q, arg_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [15:0] pixel_color_q, pixel_color_d, pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [15:0] xstart_q, xstart_d, xend_q, xend_d, ystart_q, ystart_d, yend_q, yend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      csn_sync_q  <= 2'b11;
      dcn_sync_q  <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      csn_sync_q  <= {csn_sync_q[0], csn};
      dcn_sync_q  <= {dcn_sync_q[0], dcn};
    end
  end

  assign sclk_s = SYNC_EN ? sclk_sync_q[1] : sclk;
  assign mosi_s = SYNC_EN ? mosi_sync_q[1] : mosi;
  assign csn_s  = SYNC_EN ? csn_sync_q[1]  : csn;
  assign dcn_s  = SYNC_EN ? dcn_sync_q[1]  : dcn;

  // An edge landing on the same clk as the csn rise still counts, so a byte
  // finishing exactly as the frame closes is kept.
  assign edge_ok  = sclk_s & ~sclk_prev_q & (~csn_s | ~csn_prev_q);
  assign new_byte = {shift_q, mosi_s};

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dcn_d   = byte_dcn_q;
    frame_err_d  = 1'b0;
    byte_done    = 1'b0;
    if (edge_ok) begin
      shift_d   = new_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done    = 1'b1;
        byte_valid_d = 1'b1;
        byte_data_d  = new_byte;
        byte_dcn_d   = dcn_s;
      end
    end else if (csn_s) begin
      bit_cnt_d   = 3'd0;
      frame_err_d = (bit_cnt_q != 3'd0);
    end
  end

  always_comb begin
    state_d       = state_q;
    arg_d         = arg_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    ptr_x_d       = ptr_x_q;
    ptr_y_d       = ptr_y_q;
    pixel_valid_d = 1'b0;
    pixel_color_d = pixel_color_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    xstart_d      = xstart_q;
    xend_d        = xend_q;
    ystart_d      = ystart_q;
    yend_d        = yend_q;
    if (byte_done && !dcn_s) begin
      arg_d   = 3'd0;
      phase_d = 1'b0;
      case (new_byte)
        8'h2A:   state_d = ST_CASET;
        8'h2B:   state_d = ST_PASET;
        8'h2C: begin
          state_d = ST_RAMWR;
          ptr_x_d = xstart_q;
          ptr_y_d = ystart_q;
        end
        default: state_d = ST_IGNORE;
      endcase
    end else if (byte_done) begin
      case (state_q)
        ST_CASET, ST_PASET: begin
          if (arg_q < 3'd4) arg_d = arg_q + 3'd1;
          case ({state_q == ST_PASET, arg_q})
            4'b0000: xstart_d[15:8] = new_byte;
            4'b0001: xstart_d[7:0]  = new_byte;
            4'b0010: xend_d[15:8]   = new_byte;
            4'b0011: xend_d[7:0]    = new_byte;
            4'b1000: ystart_d[15:8] = new_byte;
            4'b1001: ystart_d[7:0]  = new_byte;
            4'b1010: yend_d[15:8]   = new_byte;
            4'b1011: yend_d[7:0]    = new_byte;
            default: ;
          endcase
        end
        ST_RAMWR: begin
          if (!phase_q) begin
            hi_d    = new_byte;
            phase_d = 1'b1;
          end else begin
            phase_d       = 1'b0;
            pixel_valid_d = 1'b1;
            pixel_color_d = {hi_q, new_byte};
            pixel_x_d     = ptr_x_q;
            pixel_y_d     = ptr_y_q;
            if (ptr_x_q == xend_q) begin
              ptr_x_d = xstart_q;
              ptr_y_d = (ptr_y_q == yend_q) ? ystart_q : ptr_y_q + 16'd1;
            end else begin
              ptr_x_d = ptr_x_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q   <= 1'b0;
      csn_prev_q    <= 1'b1;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'd0;
      byte_dcn_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      state_q       <= ST_IDLE;
      arg_q         <= 3'd0;
      phase_q       <= 1'b0;
      hi_q          <= 8'd0;
      ptr_x_q       <= 16'd0;
      ptr_y_q       <= 16'd0;
      pixel_valid_q <= 1'b0;
      pixel_color_q <= 16'd0;
      pixel_x_q     <= 16'd0;
      pixel_y_q     <= 16'd0;
      xstart_q      <= 16'd0;
      xend_q        <= XDEF_END;
      ystart_q      <= 16'd0;
      yend_q        <= YDEF_END;
    end else begin
      sclk_prev_q   <= sclk_s;
      csn_prev_q    <= csn_s;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      byte_dcn_q    <= byte_dcn_d;
      frame_err_q   <= frame_err_d;
      state_q       <= state_d;
      arg_q         <= arg_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      ptr_x_q       <= ptr_x_d;
      ptr_y_q       <= ptr_y_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_color_q <= pixel_color_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      xstart_q      <= xstart_d;
      xend_q        <= xend_d;
      ystart_q      <= ystart_d;
      yend_q        <= yend_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_dcn    = byte_dcn_q;
  assign frame_err   = frame_err_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_color = pixel_color_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign win_xstart  = xstart_q;
  assign win_xend    = xend_q;
  assign win_ystart  = ystart_q;
  assign win_yend    = yend_q;

endmodule
